// File: rtl/dac_i2s_pkg.sv
// Shared definitions for the I2S DAC transmit engine: slot FSM encodings and
// the bit-counter width helper.
package dac_i2s_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LEFT  = 2'd1;
    localparam logic [1:0] S_RIGHT = 2'd2;

    function automatic int bit_cnt_width(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed stereo frames.
module sample_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + PTR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac_i2s_stream_tx.sv
// I2S transmit engine: buffers stereo frames and serialises them MSB-first on
// DACDAT, one BCLK after each codec LRCK edge, with mono and underrun support.
module dac_i2s_stream_tx
    import dac_i2s_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              i_BCLK,
    input  logic              i_rst_n,
    input  logic              i_DACLRCK,
    input  logic              i_play,
    input  logic              i_mono,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data_l,
    input  logic [DATA_W-1:0] i_data_r,
    output logic              o_DACDAT,
    output logic              o_underrun,
    output logic [LVL_W-1:0]  o_level
);

    localparam int CNT_W = bit_cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic                lrck_q;
    logic                left_edge;
    logic                right_edge;
    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   shift_l;
    logic [DATA_W-1:0]   shift_r;
    logic [2*DATA_W-1:0] rdata;
    logic [DATA_W-1:0]   rd_l;
    logic [DATA_W-1:0]   rd_r;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                cur_bit;

    assign left_edge  = lrck_q && !i_DACLRCK;
    assign right_edge = !lrck_q && i_DACLRCK;
    assign o_ready    = !fifo_full;
    assign push       = i_valid && o_ready;
    assign pop        = left_edge && i_play && !fifo_empty;
    assign rd_l       = rdata[2*DATA_W-1:DATA_W];
    assign rd_r       = rdata[DATA_W-1:0];
    assign cur_bit    = (state == S_LEFT) ? shift_l[DATA_W-1] : shift_r[DATA_W-1];

    sample_fifo #(
        .W     (2 * DATA_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (i_BCLK),
        .rst_n (i_rst_n),
        .push  (push),
        .wdata ({i_data_l, i_data_r}),
        .pop   (pop),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_level)
    );

    // An LRCK edge always wins over an in-progress slot: the edge cycle
    // drives 0 and any unsent bits of the old slot are discarded.
    always_ff @(posedge i_BCLK) begin
        if (!i_rst_n) begin
            lrck_q     <= 1'b1;
            state      <= S_IDLE;
            cnt        <= '0;
            shift_l    <= '0;
            shift_r    <= '0;
            o_DACDAT   <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            lrck_q     <= i_DACLRCK;
            o_underrun <= left_edge && i_play && fifo_empty;
            if (left_edge) begin
                state    <= S_LEFT;
                cnt      <= '0;
                o_DACDAT <= 1'b0;
                if (pop) begin
                    shift_l <= rd_l;
                    shift_r <= i_mono ? rd_l : rd_r;
                end else begin
                    shift_l <= '0;
                    shift_r <= '0;
                end
            end else if (right_edge) begin
                state    <= S_RIGHT;
                cnt      <= '0;
                o_DACDAT <= 1'b0;
            end else if (state == S_LEFT || state == S_RIGHT) begin
                o_DACDAT <= i_play && cur_bit;
                if (state == S_LEFT) begin
                    shift_l <= {shift_l[DATA_W-2:0], 1'b0};
                end else begin
                    shift_r <= {shift_r[DATA_W-2:0], 1'b0};
                end
                if (cnt == LAST_BIT) begin
                    state <= S_IDLE;
                end
                cnt <= cnt + CNT_W'(1);
            end else begin
                state    <= S_IDLE;
                o_DACDAT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_i2s_stream_tx.sv
// Directed bench for dac_i2s_stream_tx: a 16-bit instance for the main
// scenarios and a 24-bit instance for short-slot truncation.
module tb_dac_i2s_stream_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, lrck, play, mono, valid, ready, dacdat, underrun;
    logic [15:0] dl, dr;
    logic [2:0]  level;

    logic        lrck24, valid24, ready24, dacdat24, underrun24;
    logic [23:0] dl24, dr24;
    logic [2:0]  level24;

    int n_checks = 0;
    int n_fail   = 0;

    dac_i2s_stream_tx u_dut (
        .i_BCLK     (clk),
        .i_rst_n    (rst_n),
        .i_DACLRCK  (lrck),
        .i_play     (play),
        .i_mono     (mono),
        .i_valid    (valid),
        .o_ready    (ready),
        .i_data_l   (dl),
        .i_data_r   (dr),
        .o_DACDAT   (dacdat),
        .o_underrun (underrun),
        .o_level    (level)
    );

    dac_i2s_stream_tx #(.DATA_W(24), .FIFO_DEPTH(4)) u_dut24 (
        .i_BCLK     (clk),
        .i_rst_n    (rst_n),
        .i_DACLRCK  (lrck24),
        .i_play     (play),
        .i_mono     (mono),
        .i_valid    (valid24),
        .o_ready    (ready24),
        .i_data_l   (dl24),
        .i_data_r   (dr24),
        .o_DACDAT   (dacdat24),
        .o_underrun (underrun24),
        .o_level    (level24)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One left slot then one right slot, each 17 BCLKs long; 16 data bits
    // follow each edge, then a 0. lrck is left high afterwards.
    task automatic run_frame(input string name, input logic [15:0] exp_l,
                             input logic [15:0] exp_r, input int exp_lvl,
                             input logic exp_und);
        lrck = 1'b0;
        cyc();
        valid = 1'b0;
        mono  = 1'b0;
        n_checks++;
        if (level !== 3'(exp_lvl)) begin
            n_fail++;
            $display("FAIL %s level_after_left_edge: got %0d expected %0d", name, level, exp_lvl);
        end
        n_checks++;
        if (underrun !== exp_und) begin
            n_fail++;
            $display("FAIL %s underrun_at_left_edge: got %b expected %b", name, underrun, exp_und);
        end
        for (int i = 0; i < 16; i++) begin
            cyc();
            n_checks++;
            if (dacdat !== exp_l[15-i]) begin
                n_fail++;
                $display("FAIL %s left_bit%0d: got %b expected %b", name, i, dacdat, exp_l[15-i]);
            end
            if (i == 0) begin
                n_checks++;
                if (underrun !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s underrun_pulse_width: got %b expected 0", name, underrun);
                end
            end
        end
        lrck = 1'b1;
        cyc();
        n_checks++;
        if (dacdat !== 1'b0) begin
            n_fail++;
            $display("FAIL %s right_edge_cycle: got %b expected 0", name, dacdat);
        end
        for (int i = 0; i < 16; i++) begin
            cyc();
            n_checks++;
            if (dacdat !== exp_r[15-i]) begin
                n_fail++;
                $display("FAIL %s right_bit%0d: got %b expected %b", name, i, dacdat, exp_r[15-i]);
            end
        end
        cyc();
        n_checks++;
        if (dacdat !== 1'b0 || level !== 3'(exp_lvl)) begin
            n_fail++;
            $display("FAIL %s idle_after_slot: dacdat %b level %0d expected 0 and %0d", name, dacdat, level, exp_lvl);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; lrck = 1'b1; lrck24 = 1'b1; play = 1'b0; mono = 1'b0;
        valid = 1'b0; valid24 = 1'b0; dl = '0; dr = '0; dl24 = '0; dr24 = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        n_checks++;
        if (dacdat !== 1'b0 || underrun !== 1'b0 || level !== 3'd0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: dacdat %b underrun %b level %0d ready %b expected 0 0 0 1", dacdat, underrun, level, ready);
        end
    endtask

    task automatic test_stereo();
        play = 1'b1;
        valid = 1'b1; dl = 16'hA5F0; dr = 16'h0F3C;
        cyc();
        valid = 1'b0;
        n_checks++;
        if (level !== 3'd1) begin
            n_fail++;
            $display("FAIL stereo_push_level: got %0d expected 1", level);
        end
        run_frame("stereo", 16'hA5F0, 16'h0F3C, 0, 1'b0);
    endtask

    task automatic test_mono();
        mono = 1'b1;
        valid = 1'b1; dl = 16'h8001; dr = 16'h7FFF;
        cyc();
        valid = 1'b0;
        run_frame("mono", 16'h8001, 16'h8001, 0, 1'b0);
    endtask

    task automatic test_underrun();
        run_frame("underrun", 16'h0000, 16'h0000, 0, 1'b1);
    endtask

    task automatic test_push_at_underrun();
        valid = 1'b1; dl = 16'h6B2D; dr = 16'hD4C1;
        run_frame("push_at_underrun", 16'h0000, 16'h0000, 1, 1'b1);
        run_frame("deferred_frame", 16'h6B2D, 16'hD4C1, 0, 1'b0);
    endtask

    task automatic test_pause();
        play = 1'b0;
        valid = 1'b1; dl = 16'h9C31; dr = 16'h4E07;
        cyc();
        valid = 1'b0;
        lrck = 1'b0;
        cyc();
        n_checks++;
        if (underrun !== 1'b0 || level !== 3'd1) begin
            n_fail++;
            $display("FAIL pause_edge: underrun %b level %0d expected 0 and 1", underrun, level);
        end
        for (int i = 0; i < 35; i++) begin
            if (i == 17) lrck = 1'b1;
            cyc();
            n_checks++;
            if (dacdat !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_dacdat_cycle%0d: got %b expected 0", i, dacdat);
            end
        end
        play = 1'b1;
        run_frame("resume", 16'h9C31, 16'h4E07, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        valid = 1'b1;
        for (int p = 0; p < 5; p++) begin
            dl = 16'hC350 + 16'(p);
            dr = ~dl;
            n_checks++;
            if (ready !== (p < 4)) begin
                n_fail++;
                $display("FAIL backpressure_ready_push%0d: got %b expected %b", p, ready, (p < 4));
            end
            cyc();
        end
        n_checks++;
        if (level !== 3'd4 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_full: level %0d ready %b expected 4 and 0", level, ready);
        end
        lrck = 1'b0;
        cyc();
        n_checks++;
        if (level !== 3'd3 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_after_pop: level %0d ready %b expected 3 and 1", level, ready);
        end
        cyc();
        valid = 1'b0;
        n_checks++;
        if (level !== 3'd4) begin
            n_fail++;
            $display("FAIL backpressure_fifth_accepted: level %0d expected 4", level);
        end
    endtask

    task automatic test_reset_mid_slot();
        logic [15:0] l1;
        l1 = 16'hC351;
        lrck = 1'b1;
        repeat (20) cyc();
        lrck = 1'b0;
        cyc();
        n_checks++;
        if (level !== 3'd3) begin
            n_fail++;
            $display("FAIL midreset_pop_level: got %0d expected 3", level);
        end
        for (int i = 0; i < 7; i++) begin
            cyc();
            n_checks++;
            if (dacdat !== l1[15-i]) begin
                n_fail++;
                $display("FAIL midreset_fifo_order_bit%0d: got %b expected %b", i, dacdat, l1[15-i]);
            end
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        n_checks++;
        if (dacdat !== 1'b0 || level !== 3'd0 || underrun !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_outputs: dacdat %b level %0d underrun %b ready %b expected 0 0 0 1", dacdat, level, underrun, ready);
        end
        cyc();
        n_checks++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_low_lrck_left_edge: underrun %b expected 1", underrun);
        end
        cyc();
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_underrun_clear: underrun %b expected 0", underrun);
        end
    endtask

    task automatic test_truncation();
        logic [23:0] l24;
        logic [23:0] r24;
        l24 = 24'hABCDEF;
        r24 = 24'h135790;
        valid24 = 1'b1; dl24 = l24; dr24 = r24;
        cyc();
        valid24 = 1'b0;
        n_checks++;
        if (level24 !== 3'd1) begin
            n_fail++;
            $display("FAIL trunc_push_level: got %0d expected 1", level24);
        end
        lrck24 = 1'b0;
        cyc();
        n_checks++;
        if (level24 !== 3'd0 || underrun24 !== 1'b0) begin
            n_fail++;
            $display("FAIL trunc_left_edge: level %0d underrun %b expected 0 and 0", level24, underrun24);
        end
        for (int i = 0; i < 15; i++) begin
            cyc();
            n_checks++;
            if (dacdat24 !== l24[23-i]) begin
                n_fail++;
                $display("FAIL trunc_left_bit%0d: got %b expected %b", i, dacdat24, l24[23-i]);
            end
        end
        lrck24 = 1'b1;
        cyc();
        n_checks++;
        if (dacdat24 !== 1'b0) begin
            n_fail++;
            $display("FAIL trunc_left_dropped: got %b expected 0", dacdat24);
        end
        for (int i = 0; i < 15; i++) begin
            cyc();
            n_checks++;
            if (dacdat24 !== r24[23-i]) begin
                n_fail++;
                $display("FAIL trunc_right_bit%0d: got %b expected %b", i, dacdat24, r24[23-i]);
            end
        end
        lrck24 = 1'b0;
        cyc();
        n_checks++;
        if (dacdat24 !== 1'b0 || underrun24 !== 1'b1) begin
            n_fail++;
            $display("FAIL trunc_next_left: dacdat %b underrun %b expected 0 and 1", dacdat24, underrun24);
        end
    endtask

    initial begin
        test_reset();
        test_stereo();
        test_mono();
        test_underrun();
        test_push_at_underrun();
        test_pause();
        test_backpressure();
        test_reset_mid_slot();
        test_truncation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
